// File: rtl/cbfp_denorm.sv
// CBFP block decoder: restores a fixed output scale from block-normalized FFT data.
// Optional macro CBFP_DENORM_ROUND_EN selects round-half-up right shifts (default: floor).
module cbfp_denorm #(
  parameter int IN_W      = 14,
  parameter int OUT_W     = 13,
  parameter int MAG_WIDTH = 5,
  parameter int DATA_NUM  = 8,
  parameter int BLK_CYC   = 8,
  parameter int REF_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic [MAG_WIDTH-1:0]        idx_in,
  input  logic signed [IN_W-1:0]      din_re [0:DATA_NUM-1],
  input  logic signed [IN_W-1:0]      din_im [0:DATA_NUM-1],
  output logic                        out_valid,
  output logic                        out_first,
  output logic                        out_last,
  output logic signed [OUT_W-1:0]     dout_re [0:DATA_NUM-1],
  output logic signed [OUT_W-1:0]     dout_im [0:DATA_NUM-1],
  output logic                        sat_out,
  output logic                        frame_err
);

  localparam int CNT_W = $clog2(BLK_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_CYC - 1);
  localparam int WW = IN_W + 2**MAG_WIDTH + 1;
  localparam logic [MAG_WIDTH:0] REF_S  = (MAG_WIDTH+1)'(REF_SHIFT);
  localparam logic [MAG_WIDTH:0] SH_MAX = (MAG_WIDTH+1)'(IN_W);
  localparam int MAX_I = 2**(OUT_W-1) - 1;
  localparam int MIN_I = -(2**(OUT_W-1));
  localparam logic signed [WW-1:0] MAX_W = WW'(MAX_I);
  localparam logic signed [WW-1:0] MIN_W = WW'(MIN_I);
`ifdef CBFP_DENORM_ROUND_EN
  localparam logic signed [WW-1:0] ONE_W = WW'(1);
`endif

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_BLK = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MAG_WIDTH-1:0] idx_q, idx_d;
  logic                 ferr_q, ferr_d;

  logic                 v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
  logic signed [MAG_WIDTH:0] s1_q, s1_d;
  logic signed [IN_W-1:0] re1_q [0:DATA_NUM-1];
  logic signed [IN_W-1:0] re1_d [0:DATA_NUM-1];
  logic signed [IN_W-1:0] im1_q [0:DATA_NUM-1];
  logic signed [IN_W-1:0] im1_d [0:DATA_NUM-1];

  logic                 out_valid_q, out_valid_d, out_first_q, out_first_d;
  logic                 out_last_q, out_last_d, sat_q, sat_d;
  logic signed [OUT_W-1:0] dre_q [0:DATA_NUM-1];
  logic signed [OUT_W-1:0] dre_d [0:DATA_NUM-1];
  logic signed [OUT_W-1:0] dim_q [0:DATA_NUM-1];
  logic signed [OUT_W-1:0] dim_d [0:DATA_NUM-1];

  logic                 acc;
  logic                 beat_last;
  logic [MAG_WIDTH-1:0] beat_idx;

  // Returns {saturated, value}; the widened intermediate never drops bits before the clip.
  function automatic logic [OUT_W:0] scale(input logic signed [IN_W-1:0] x,
                                           input logic signed [MAG_WIDTH:0] s);
    logic signed [WW-1:0] w;
    logic [MAG_WIDTH:0]   amt;
    logic                 sat;
    logic signed [OUT_W-1:0] y;
    w   = {{(WW-IN_W){x[IN_W-1]}}, x};
    amt = '0;
    if (!s[MAG_WIDTH] && (s != '0)) begin
      amt = ($unsigned(s) > SH_MAX) ? SH_MAX : $unsigned(s);
`ifdef CBFP_DENORM_ROUND_EN
      w = w + (ONE_W <<< (amt - 1'b1));
`endif
      w = w >>> amt;
    end else if (s[MAG_WIDTH]) begin
      amt = $unsigned(-s);
      w   = w <<< amt;
    end
    sat = 1'b0;
    if (w > MAX_W) begin
      y   = OUT_W'(MAX_I);
      sat = 1'b1;
    end else if (w < MIN_W) begin
      y   = OUT_W'(MIN_I);
      sat = 1'b1;
    end else begin
      y = w[OUT_W-1:0];
    end
    return {sat, y};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ferr_d    = ferr_q;
    acc       = 1'b0;
    beat_last = 1'b0;
    beat_idx  = idx_q;
    if (in_valid) begin
      if (in_first) begin
        // A first beat always starts a block; mid-block it truncates the old one.
        acc      = 1'b1;
        beat_idx = idx_in;
        idx_d    = idx_in;
        if (state_q == IN_BLK) ferr_d = 1'b1;
        if (BLK_CYC == 1) begin
          beat_last = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = IN_BLK;
        end
      end else if (state_q == IN_BLK) begin
        acc = 1'b1;
        if (cnt_q == LAST_CNT) begin
          beat_last = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  always_comb begin
    v1_d  = acc;
    f1_d  = f1_q;
    l1_d  = l1_q;
    s1_d  = s1_q;
    re1_d = re1_q;
    im1_d = im1_q;
    if (acc) begin
      f1_d  = in_first;
      l1_d  = beat_last;
      s1_d  = $signed({1'b0, beat_idx}) - $signed(REF_S);
      re1_d = din_re;
      im1_d = din_im;
    end
  end

  always_comb begin
    logic [OUT_W:0] r;
    out_valid_d = v1_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;
    dre_d       = dre_q;
    dim_d       = dim_q;
    r           = '0;
    if (v1_q) begin
      out_first_d = f1_q;
      out_last_d  = l1_q;
      sat_d       = 1'b0;
      for (int unsigned l = 0; l < DATA_NUM; l++) begin
        r        = scale(re1_q[l], s1_q);
        dre_d[l] = r[OUT_W-1:0];
        sat_d    = sat_d | r[OUT_W];
        r        = scale(im1_q[l], s1_q);
        dim_d[l] = r[OUT_W-1:0];
        sat_d    = sat_d | r[OUT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      ferr_q      <= 1'b0;
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      l1_q        <= 1'b0;
      s1_q        <= '0;
      re1_q       <= '{default: '0};
      im1_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      dre_q       <= '{default: '0};
      dim_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ferr_q      <= ferr_d;
      v1_q        <= v1_d;
      f1_q        <= f1_d;
      l1_q        <= l1_d;
      s1_q        <= s1_d;
      re1_q       <= re1_d;
      im1_q       <= im1_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      sat_q       <= sat_d;
      dre_q       <= dre_d;
      dim_q       <= dim_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign sat_out   = sat_q;
  assign frame_err = ferr_q;
  assign dout_re   = dre_q;
  assign dout_im   = dim_q;

endmodule

// File: tb/tb_cbfp_denorm.sv
// Directed self-checking bench for cbfp_denorm (honours CBFP_DENORM_ROUND_EN when defined).
module tb_cbfp_denorm;

  localparam int IN_W = 14;
  localparam int OUT_W = 13;
  localparam int MAG_WIDTH = 5;
  localparam int DATA_NUM = 8;
  localparam int BLK_CYC = 8;
  localparam int REF_SHIFT = 4;
`ifdef CBFP_DENORM_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic clk, rstn, in_valid, in_first;
  logic [MAG_WIDTH-1:0] idx_in;
  logic signed [IN_W-1:0] din_re [0:DATA_NUM-1];
  logic signed [IN_W-1:0] din_im [0:DATA_NUM-1];
  logic out_valid, out_first, out_last, sat_out, frame_err;
  logic signed [OUT_W-1:0] dout_re [0:DATA_NUM-1];
  logic signed [OUT_W-1:0] dout_im [0:DATA_NUM-1];

  int n_checks = 0;
  int n_fail = 0;

  cbfp_denorm #(
    .IN_W(IN_W), .OUT_W(OUT_W), .MAG_WIDTH(MAG_WIDTH),
    .DATA_NUM(DATA_NUM), .BLK_CYC(BLK_CYC), .REF_SHIFT(REF_SHIFT)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_first(in_first),
    .idx_in(idx_in), .din_re(din_re), .din_im(din_im),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .dout_re(dout_re), .dout_im(dout_im), .sat_out(sat_out), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of input (all lanes equal) and returns #1 after the capturing edge.
  task automatic step(input logic v, input logic f, input int idx, input int re, input int im);
    logic [31:0] r, m, ix;
    r = re; m = im; ix = idx;
    in_valid = v;
    in_first = f;
    idx_in   = ix[MAG_WIDTH-1:0];
    for (int l = 0; l < DATA_NUM; l++) begin
      din_re[l] = r[IN_W-1:0];
      din_im[l] = m[IN_W-1:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 ||
        sat_out !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: v=%b f=%b l=%b sat=%b ferr=%b, required all 0",
               out_valid, out_first, out_last, sat_out, frame_err);
    end
    n_checks++;
    if (dout_re[0] !== '0 || dout_im[DATA_NUM-1] !== '0) begin
      n_fail++;
      $display("FAIL reset_data: re0=%0d imN=%0d, required 0", dout_re[0], dout_im[DATA_NUM-1]);
    end
  endtask

  task automatic test_scaling();
    int t_idx [6] = '{4, 6, 1, 1, 31, 1};
    int t_re  [6] = '{1234, 14, 500, 1000, 8191, 1000};
    int t_im  [6] = '{-77, -14, -500, -1000, -8192, 5};
    int e_re  [6] = '{1234, RND ? 4 : 3, 4000, 4095, 0, 4095};
    int e_im  [6] = '{-77, RND ? -3 : -4, -4000, -4096, RND ? 0 : -1, 40};
    logic e_sat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i <= BLK_CYC; i++) begin
        step(i < BLK_CYC, i == 0, t_idx[t], t_re[t], t_im[t]);
        n_checks++;
        if (i == 0) begin
          if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL scale_latency[%0d]: out_valid=%b one cycle after first beat, required 0",
                     t, out_valid);
          end
        end else begin
          if (out_valid !== 1'b1 || out_first !== (i == 1) || out_last !== (i == BLK_CYC) ||
              $signed(dout_re[0]) !== e_re[t] || $signed(dout_im[0]) !== e_im[t] ||
              $signed(dout_re[DATA_NUM-1]) !== e_re[t] ||
              $signed(dout_im[DATA_NUM-1]) !== e_im[t] || sat_out !== e_sat[t]) begin
            n_fail++;
            $display("FAIL scale[%0d] beat %0d: v=%b f=%b l=%b re=%0d/%0d im=%0d/%0d sat=%b, required v=1 f=%b l=%b re=%0d im=%0d sat=%b",
                     t, i - 1, out_valid, out_first, out_last, dout_re[0], dout_re[DATA_NUM-1],
                     dout_im[0], dout_im[DATA_NUM-1], sat_out, i == 1, i == BLK_CYC,
                     e_re[t], e_im[t], e_sat[t]);
          end
        end
      end
      step(1'b0, 1'b0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b0 || $signed(dout_re[0]) !== e_re[t]) begin
        n_fail++;
        $display("FAIL scale_hold[%0d]: v=%b re=%0d, required v=0 re=%0d",
                 t, out_valid, dout_re[0], e_re[t]);
      end
    end
  endtask

  task automatic test_framing();
    do_reset();
    step(1'b1, 1'b0, 4, 100, 100);
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL orphan_ferr: frame_err=%b, required 1", frame_err);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b0 || frame_err !== 1'b1) begin
        n_fail++;
        $display("FAIL orphan_drop[%0d]: v=%b ferr=%b, required v=0 ferr=1", i, out_valid, frame_err);
      end
    end

    do_reset();
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_clear: frame_err=%b, required 0", frame_err);
    end
    // Old block idx 4 for beats 0..2, truncated by a new block (idx 5) at beat 3.
    for (int i = 0; i <= 11; i++) begin
      int b, ev;
      b = i - 1;
      if (i < 3) step(1'b1, i == 0, 4, 10, -10);
      else if (i < 11) step(1'b1, i == 3, 5, 10, -10);
      else step(1'b0, 1'b0, 0, 0, 0);
      if (i == 2 || i == 3) begin
        n_checks++;
        if (frame_err !== (i == 3)) begin
          n_fail++;
          $display("FAIL trunc_ferr step %0d: frame_err=%b, required %b", i, frame_err, i == 3);
        end
      end
      if (i >= 1) begin
        ev = (b < 3) ? 10 : 5;
        n_checks++;
        if (out_valid !== 1'b1 || out_first !== (b == 0 || b == 3) || out_last !== (b == 10) ||
            $signed(dout_re[0]) !== ev || $signed(dout_im[DATA_NUM-1]) !== -ev) begin
          n_fail++;
          $display("FAIL trunc beat %0d: v=%b f=%b l=%b re=%0d im=%0d, required v=1 f=%b l=%b re=%0d im=%0d",
                   b, out_valid, out_first, out_last, dout_re[0], dout_im[DATA_NUM-1],
                   b == 0 || b == 3, b == 10, ev, -ev);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i <= 18; i++) begin
      int b, ev;
      b = i - 1;
      if (i == 18) rstn = 1'b0;
      if (i < 8) step(1'b1, i == 0, 4, 100, -100);
      else if (i < 16) step(1'b1, i == 8, 5, 100, -100);
      else step(1'b1, i == 16, 4, 7, -7);
      if (i >= 1 && i < 18) begin
        ev = (b < 8) ? 100 : (b < 16) ? 50 : 7;
        n_checks++;
        if (out_valid !== 1'b1 || out_first !== (b == 0 || b == 8 || b == 16) ||
            out_last !== (b == 7 || b == 15) || $signed(dout_re[DATA_NUM-1]) !== ev ||
            $signed(dout_im[0]) !== -ev) begin
          n_fail++;
          $display("FAIL b2b beat %0d: v=%b f=%b l=%b re=%0d im=%0d, required v=1 f=%b l=%b re=%0d im=%0d",
                   b, out_valid, out_first, out_last, dout_re[DATA_NUM-1], dout_im[0],
                   b == 0 || b == 8 || b == 16, b == 7 || b == 15, ev, -ev);
        end
      end
    end
    rstn = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 || sat_out !== 1'b0 ||
        frame_err !== 1'b0 || dout_re[0] !== '0 || dout_im[0] !== '0) begin
      n_fail++;
      $display("FAIL midblk_reset: v=%b f=%b l=%b sat=%b ferr=%b re=%0d im=%0d, required all 0",
               out_valid, out_first, out_last, sat_out, frame_err, dout_re[0], dout_im[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b0 || dout_re[DATA_NUM-1] !== '0) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: v=%b re=%0d, required v=0 re=0", i, out_valid, dout_re[DATA_NUM-1]);
      end
    end
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    idx_in   = '0;
    for (int l = 0; l < DATA_NUM; l++) begin
      din_re[l] = '0;
      din_im[l] = '0;
    end
    test_reset();
    test_scaling();
    test_framing();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
